// File: rtl/ser_frame_rx.sv
// rtl/ser_frame_rx.sv - serial frame receiver (start, DATA_W bits LSB first, optional parity, stop)
// All state advances on the falling edge of clk to line up with the capture stage feeding sdi.
module ser_frame_rx #(
   parameter int DATA_W     = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              sdi,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt, dout_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              par_bit, par_nxt;
   logic              dv_nxt, pe_nxt, fe_nxt;
   logic              par_ok;

   assign par_ok = !PARITY_EN || ((^shreg ^ par_bit) == PARITY_ODD);
   assign busy   = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      par_nxt   = par_bit;
      dout_nxt  = data_out;
      dv_nxt    = 1'b0;
      pe_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      if (bit_en) begin
         case (state)
            S_IDLE: begin
               if (!sdi) begin
                  state_nxt = S_DATA;
                  cnt_nxt   = '0;
               end
            end
            S_DATA: begin
               shreg_nxt[cnt] = sdi;
               // Counter holds on the last bit so it never wraps inside a frame.
               if (cnt == CW'(DATA_W - 1)) state_nxt = PARITY_EN ? S_PARITY : S_STOP;
               else                         cnt_nxt   = cnt + 1'b1;
            end
            S_PARITY: begin
               par_nxt   = sdi;
               state_nxt = S_STOP;
            end
            S_STOP: begin
               if (sdi) begin
                  dout_nxt  = shreg;
                  dv_nxt    = par_ok;
                  pe_nxt    = !par_ok;
                  state_nxt = S_IDLE;
               end else begin
                  fe_nxt    = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
            S_BREAK: begin
               // A held-low line is a break, not a start bit.
               if (sdi) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         shreg      <= '0;
         cnt        <= '0;
         par_bit    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         cnt        <= cnt_nxt;
         par_bit    <= par_nxt;
         data_out   <= dout_nxt;
         data_valid <= dv_nxt;
         parity_err <= pe_nxt;
         frame_err  <= fe_nxt;
      end
   end

endmodule

// File: tb/tb_ser_frame_rx.sv
// tb/tb_ser_frame_rx.sv - self-checking bench for ser_frame_rx
// Inputs change on the rising edge; the DUT samples on the falling edge; outputs are read on the rising edge.
module tb_ser_frame_rx;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       sdi;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int cyc = 0, dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, multi_cnt = 0;
   int last_dv_cyc = 0, prev_dv_cyc = 0;

   int         exp_dv = 0, exp_pe = 0, exp_fe = 0;
   logic [7:0] exp_dout = 8'h00;

   ser_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .sdi        (sdi),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (data_valid) begin
         dv_cnt      <= dv_cnt + 1;
         last_dv_cyc <= cyc;
         prev_dv_cyc <= last_dv_cyc;
      end
      if (parity_err) pe_cnt <= pe_cnt + 1;
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (int'(data_valid) + int'(parity_err) + int'(frame_err) > 1) multi_cnt <= multi_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One bit period: sdi stable for `period` clocks, bit_en only in the last one.
   task automatic send_bit(input logic b, input int period);
      for (int i = 0; i < period; i++) begin
         sdi    = b;
         bit_en = (i == period - 1);
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1, 1);
   endtask

   // Sends a frame, updates the reference model and checks the pulse cycle.
   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input int period);
      int ones;
      logic ok;
      send_bit(1'b0, period);
      for (int i = 0; i < 8; i++) send_bit(d[i], period);
      send_bit(pbit, period);
      send_bit(stopb, period);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      ok = ((ones + int'(pbit)) % 2) == 0;
      if (!stopb) exp_fe++;
      else begin
         exp_dout = d;
         if (ok) exp_dv++;
         else    exp_pe++;
      end
      check("dv_pulse", data_valid, stopb && ok);
      check("pe_pulse", parity_err, stopb && !ok);
      check("fe_pulse", frame_err, !stopb);
      check("data_out", data_out, exp_dout);
      check("busy_after_stop", busy, !stopb);
   endtask

   task automatic check_counts();
      check("dv_count", dv_cnt, exp_dv);
      check("pe_count", pe_cnt, exp_pe);
      check("fe_count", fe_cnt, exp_fe);
      check("multi_pulse", multi_cnt, 0);
   endtask

   initial begin
      rst    = 1'b0;
      sdi    = 1'b1;
      bit_en = 1'b0;
      repeat (2) @(posedge clk);
      check("rst_data_out", data_out, 0);
      check("rst_dv", data_valid, 0);
      check("rst_busy", busy, 0);
      #2 rst = 1'b1;
      @(posedge clk);
      idle(2);

      // Directed: good frame, bad parity, stop error with break, recovery.
      send_frame(8'hA5, 1'b0, 1'b1, 1);
      idle(1);
      check("a5_dv_width", data_valid, 0);
      check("a5_busy_idle", busy, 0);
      send_frame(8'h3C, 1'b1, 1'b1, 1);
      idle(1);
      send_frame(8'h81, 1'b0, 1'b0, 1);
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
      check("break_busy", busy, 1);
      check("break_no_dv", data_valid, 0);
      send_bit(1'b1, 1);
      check("break_exit", busy, 0);
      send_frame(8'h7E, 1'b0, 1'b1, 1);
      idle(2);
      check_counts();

      // Sparse bit_en.
      send_frame(8'hA5, 1'b0, 1'b1, 4);
      sdi = 1'b1; bit_en = 1'b0;
      @(posedge clk);
      check("slow_dv_width", data_valid, 0);
      idle(2);
      check_counts();

      // Asynchronous reset mid-frame.
      send_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i), 1);
      #2 rst = 1'b0;
      #1;
      exp_dout = 8'h00;
      check("amid_data_out", data_out, 0);
      check("amid_busy", busy, 0);
      check("amid_dv", data_valid, 0);
      check("amid_pe", parity_err, 0);
      check("amid_fe", frame_err, 0);
      @(posedge clk);
      sdi = 1'b1; bit_en = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk);
      send_frame(8'h5A, 1'b0, 1'b1, 1);
      idle(2);
      check_counts();

      // Back-to-back frames.
      send_frame(8'h01, 1'b1, 1'b1, 1);
      send_frame(8'hFF, 1'b0, 1'b1, 1);
      idle(2);
      check("b2b_spacing", last_dv_cyc - prev_dv_cyc, 11);
      check_counts();

      // Randomized frames.
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic       pbit, stopb;
         int         period;
         d      = 8'($urandom);
         pbit   = (^d) ^ ($urandom_range(0, 4) == 0);
         stopb  = ($urandom_range(0, 9) != 0);
         period = $urandom_range(1, 3);
         send_frame(d, pbit, stopb, period);
         if (!stopb) send_bit(1'b1, period);
         for (int k = $urandom_range(0, 2); k > 0; k--) send_bit(1'b1, $urandom_range(1, 3));
      end
      idle(2);
      check_counts();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
